alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 218 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative shift-add multiply
// and restoring divide, sharing one IDLE/RUN/DONE issue state machine.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SLTU   = 5'b00110;
  localparam logic [4:0] OP_SLL    = 5'b00111;
  localparam logic [4:0] OP_SRL    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHU  = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_DIVU   = 5'b10001;
  localparam logic [4:0] OP_REM    = 5'b10010;
  localparam logic [4:0] OP_REMU   = 5'b10011;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic [4:0]       op_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, dvsr_r;
  logic             neg_q_r, neg_r_r;

  logic             sa_s, sb_s, iter_s, neg_q_s, neg_r_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s, single_s;
  logic [WIDTH:0]   mul_sum_s, div_trial_s, div_diff_s;
  logic [WIDTH-1:0] next_hi_s, next_lo_s, quo_s, rem_s, final_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  function automatic logic is_div(input logic [4:0] op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_iter(input logic [4:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU: return 1'b1;
      default:                              return is_div(op);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] alu_single(input logic [4:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $unsigned($signed(a) >>> sh);
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  // Issue-side decode: operand magnitudes and result sign flags for iterative ops
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (ALUControl)
      OP_MULH, OP_DIV, OP_REM: begin
        sa_s = srcA[WIDTH-1];
        sb_s = srcB[WIDTH-1];
      end
      OP_MULHSU: sa_s = srcA[WIDTH-1];
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    mag_a_s  = sa_s ? -srcA : srcA;
    mag_b_s  = sb_s ? -srcB : srcB;
    iter_s   = is_iter(ALUControl);
    single_s = alu_single(ALUControl, srcA, srcB);
    // A zero divisor must yield an all-ones quotient regardless of dividend sign
    if (is_div(ALUControl)) begin
      neg_q_s = (sa_s ^ sb_s) && (srcB != {WIDTH{1'b0}});
      neg_r_s = sa_s;
    end else begin
      neg_q_s = sa_s ^ sb_s;
      neg_r_s = 1'b0;
    end
  end

  // One iteration step: hi/lo hold product halves, or remainder/quotient
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dvsr_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_trial_s - {1'b0, dvsr_r};
    if (is_div(op_r)) begin
      if (!div_diff_s[WIDTH]) begin
        next_hi_s = div_diff_s[WIDTH-1:0];
        next_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        next_hi_s = div_trial_s[WIDTH-1:0];
        next_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi_s = mul_sum_s[WIDTH:1];
      next_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Sign fixup and result select applied on the last iteration edge
  always_comb begin
    prod_s = {next_hi_s, next_lo_s};
    if (neg_q_r) begin
      prod_fix_s = -prod_s;
      quo_s      = -next_lo_s;
    end else begin
      prod_fix_s = prod_s;
      quo_s      = next_lo_s;
    end
    rem_s = neg_r_r ? -next_hi_s : next_hi_s;
    case (op_r)
      OP_MUL:                        final_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:  final_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               final_s = quo_s;
      OP_REM, OP_REMU:               final_s = rem_s;
      default:                       final_s = {WIDTH{1'b0}};
    endcase
  end

  // Issue state machine, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= 5'd0;
      cnt_r   <= {SHW{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      dvsr_r  <= {WIDTH{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      result  <= {WIDTH{1'b0}};
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          hi_r  <= next_hi_s;
          lo_r  <= next_lo_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST) begin
            state_r <= DONE;
            result  <= final_s;
            zero    <= (final_s == {WIDTH{1'b0}});
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= RUN;
          end
        end
        IDLE, DONE: begin
          if (start) begin
            op_r    <= ALUControl;
            lo_r    <= mag_a_s;
            dvsr_r  <= mag_b_s;
            hi_r    <= {WIDTH{1'b0}};
            cnt_r   <= {SHW{1'b0}};
            neg_q_r <= neg_q_s;
            neg_r_r <= neg_r_s;
            if (iter_s) begin
              state_r <= RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
            end else begin
              state_r <= DONE;
              result  <= single_s;
              zero    <= (single_s == {WIDTH{1'b0}});
              done    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expected results and done
// cycles; a negedge monitor pops and compares whenever done is seen.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [4:0]   ALUControl;
  logic [W-1:0] srcA, srcB, result;
  logic         zero, busy, done;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
    .srcA(srcA), .srcB(srcB), .result(result), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int unsigned dc;
    logic [4:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          compared = 0;
  int          mismatched = 0;
  int unsigned busy_until = 0;
  logic [31:0] held_exp = 32'd0;

  localparam int NOPS = 22;
  logic [4:0] ops[NOPS] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                            5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                            5'b01100, 5'b01101, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
                            5'b01110, 5'b10100, 5'b11111, 5'b01111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour written from the operation definitions with wide arithmetic
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    logic signed [63:0] xa, xb, sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (op)
      5'b00000: return a + b;
      5'b00001: return a - b;
      5'b00010: return a & b;
      5'b00011: return a | b;
      5'b00100: return a ^ b;
      5'b00101: return (sa < sb) ? 32'd1 : 32'd0;
      5'b00110: return (a < b) ? 32'd1 : 32'd0;
      5'b00111: return a << b[4:0];
      5'b01000: return a >> b[4:0];
      5'b01001: return 32'(sa >>> b[4:0]);
      5'b01010: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      5'b01011: begin xa = sa; xb = sb; sp = xa * xb; return sp[63:32]; end
      5'b01100: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      5'b01101: begin xa = sa; xb = {32'd0, b}; sp = xa * xb; return sp[63:32]; end
      5'b10000: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        else return 32'(sa / sb);
      end
      5'b10001: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'b10010: begin
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return 32'(sa % sb);
      end
      5'b10011: return (b == 32'd0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int unsigned latency(input logic [4:0] op);
    case (op)
      5'b01010, 5'b01011, 5'b01100, 5'b01101,
      5'b10000, 5'b10001, 5'b10010, 5'b10011: return 33;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_free();
    while (cyc < busy_until) @(negedge clk);
  endtask

  // Issue one op at a negedge once the DUT can accept; returns on the next negedge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    exp_t e;
    wait_free();
    ALUControl = op;
    srcA = a;
    srcB = b;
    start = 1'b1;
    e.res = exp;
    e.z = (exp == 32'd0);
    e.dc = cyc + latency(op);
    e.op = op;
    sb_q.push_back(e);
    busy_until = e.dc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: pops expectations on done, flags late or unexpected done, checks hold during RUN
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].dc < cyc) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: op %b expected done at cycle %0d, still pending at cycle %0d",
               sb_q[0].op, sb_q[0].dc, cyc);
      void'(sb_q.pop_front());
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done: done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.res);
        check("zero", {31'd0, zero}, {31'd0, mon_e.z});
        check("done_cycle", cyc, mon_e.dc);
        held_exp = mon_e.res;
      end
    end
    if (busy) check("held_result", result, held_exp);
  end

  initial begin
    int nb;
    logic [4:0]  op;
    logic [31:0] a, b;
    reset = 1'b1;
    start = 1'b0;
    ALUControl = 5'd0;
    srcA = 32'd0;
    srcB = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    busy_until = cyc;
    @(negedge clk);

    issue(5'b00000, 32'd7, 32'd5, 32'd12);
    issue(5'b00001, 32'd5, 32'd5, 32'd0);
    issue(5'b01001, 32'h8000_0000, 32'd36, 32'hF800_0000);
    issue(5'b00101, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue(5'b00110, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue(5'b11111, 32'd3, 32'd4, 32'd0);
    issue(5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    issue(5'b01011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue(5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    nb = 0;
    while (cyc < busy_until) begin
      if (busy) nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, 32'd32);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    issue(5'b10000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(5'b10010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(5'b10000, 32'd7, 32'd0, 32'hFFFF_FFFF);
    issue(5'b10011, 32'd7, 32'd0, 32'd7);
    issue(5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue(5'b00000, 32'd1, 32'd1, 32'd2);
    issue(5'b01101, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

    // ADD requested mid-RUN must be dropped; DIVU result and done count unchanged
    issue(5'b10001, 32'd1000, 32'd7, 32'd142);
    repeat (4) @(negedge clk);
    ALUControl = 5'b00000;
    srcA = 32'd1;
    srcB = 32'd2;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_free();
    repeat (3) @(negedge clk);

    // Reset at RUN cycle 10 aborts the divide with no done pulse
    issue(5'b10000, 32'd100, 32'd3, 32'd33);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    held_exp = 32'd0;
    busy_until = cyc;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);
    issue(5'b10000, 32'd100, 32'd3, 32'd33);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_free();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      op = ops[$urandom_range(0, NOPS - 1)];
      a = rnd_operand();
      b = rnd_operand();
      issue(op, a, b, model(op, a, b));
    end

    wait_free();
    repeat (5) @(negedge clk);
    check("queue_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
